// File: rtl/booth_mult_r4_if.sv
// Start/valid handshake bundle for the radix-4 Booth multiplier.
// The requester drives operands and start; the multiplier returns the product and status.
interface booth_mult_r4_if #(
    parameter int WIDTH = 32
) ();
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic [2*WIDTH-1:0]   result;
    logic                 valid;
    logic                 busy;

    modport master (
        output start, signed_mode, x, y,
        input  result, valid, busy
    );

    modport slave (
        input  start, signed_mode, x, y,
        output result, valid, busy
    );
endinterface

// File: rtl/booth_mult_r4.sv
// Iterative radix-4 Booth multiplier: one recoded digit per clock, WIDTH/2+1 clocks per product.
// state    | meaning
// S_IDLE   | waiting for start, busy=0, operands may be latched
// S_RUN    | one Booth step per clock, busy=1
module booth_mult_r4 #(
    parameter int WIDTH = 32
) (
    input logic           clk_i,
    input logic           reset_i,
    booth_mult_r4_if.slave bus
);
    localparam int N_STEPS = WIDTH / 2 + 1;
    localparam int EW      = WIDTH + 2;
    localparam int AW      = WIDTH + 4;
    localparam int CW      = $clog2(N_STEPS + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      p_q, p_d;
    logic [EW-1:0]      m_q, m_d;
    logic [EW-1:0]      y_q, y_d;
    logic               mlsb_q, mlsb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               valid_q, valid_d;
    logic               busy;
    logic               last_step;

    logic [EW-1:0]      x_ext, y_ext_in;
    logic [AW-1:0]      y_wide, addend, sum;
    logic [AW-1:0]      p_step;
    logic [EW-1:0]      m_step;

    assign last_step = (cnt_q == CW'(N_STEPS - 1));

    // Two extra bits make unsigned operands exact under signed recoding.
    assign x_ext    = bus.signed_mode ? {{2{bus.x[WIDTH-1]}}, bus.x} : {2'b00, bus.x};
    assign y_ext_in = bus.signed_mode ? {{2{bus.y[WIDTH-1]}}, bus.y} : {2'b00, bus.y};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_RUN;
            S_RUN:  if (last_step) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
    end

    // Radix-4 digit from {m[1], m[0], m[-1]}; upper part is two bits wider than 2Y needs.
    always_comb begin
        y_wide = {{2{y_q[EW-1]}}, y_q};
        case ({m_q[1:0], mlsb_q})
            3'b001, 3'b010: addend = y_wide;
            3'b011:         addend = y_wide << 1;
            3'b100:         addend = -(y_wide << 1);
            3'b101, 3'b110: addend = -y_wide;
            default:        addend = '0;
        endcase
        sum    = p_q + addend;
        p_step = {{2{sum[AW-1]}}, sum[AW-1:2]};
        m_step = {sum[1:0], m_q[EW-1:2]};
    end

    always_comb begin
        p_d      = p_q;
        m_d      = m_q;
        y_d      = y_q;
        mlsb_d   = mlsb_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    p_d    = '0;
                    m_d    = x_ext;
                    y_d    = y_ext_in;
                    mlsb_d = 1'b0;
                    cnt_d  = '0;
                end
            end
            S_RUN: begin
                p_d    = p_step;
                m_d    = m_step;
                mlsb_d = m_q[1];
                cnt_d  = cnt_q + CW'(1);
                if (last_step) begin
                    result_d = {p_step[WIDTH-3:0], m_step};
                    valid_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            p_q      <= '0;
            m_q      <= '0;
            y_q      <= '0;
            mlsb_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            p_q      <= p_d;
            m_q      <= m_d;
            y_q      <= y_d;
            mlsb_q   <= mlsb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.result = result_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy;
endmodule

// File: doc/booth_mult_r4.md
# booth_mult_r4

Parametrised, iterative radix-4 Booth multiplier. It is the next generation of the team's serial radix-2 Booth multiplier, with these additions:
- configurable operand width;
- run-time signed/unsigned mode;
- operands latched at start;
- a `busy` indication;
- roughly half the latency.

It sits as a multi-cycle arithmetic unit behind a simple start/valid handshake. It is used wherever area matters more than single-cycle throughput.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be even and ≥ 4.
- `clk`  in  1: single clock. All state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a multiply. Accepted only on an edge where `busy`=0.
- `signed_mode`  in  1: 1 = two's-complement operands, 0 = unsigned. Sampled with `start`.
- `x`  in  WIDTH: multiplier. Sampled only on the accepting edge.
- `y`  in  WIDTH: multiplicand. Sampled only on the accepting edge.
- `result`  out  2*WIDTH: product. Registered and stable between completions.
- `valid`  out  1: one-cycle pulse marking a new `result`.
- `busy`  out  1: high while a multiply is in progress.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- IDLE → RUN on an edge with `start`=1. That edge does the following:
  - latches `ext(x)` and `ext(y)`, each WIDTH+2 bits;
  - clears the accumulator upper half;
  - clears the implicit bit m[-1] to 0;
  - clears the iteration counter.
- Operand extension: sign-extend when `signed_mode`=1, zero-extend when `signed_mode`=0. The two extra bits make unsigned operands exact under signed Booth recoding.
- RUN performs one radix-4 step per clock, for N = WIDTH/2 + 1 steps (17 for WIDTH=32).
- Each step examines the triplet {m[2i+1], m[2i], m[2i-1]} and adds to the accumulator upper part:
  - 000 → 0; 001 → +Y; 010 → +Y; 011 → +2Y;
  - 100 → −2Y; 101 → −Y; 110 → −Y; 111 → 0.
  - The step then arithmetic-shifts the accumulator right by 2.
- Internal upper-part arithmetic is WIDTH+4 bits wide, so ±2Y never overflows.
- Final step:
  - `result` ← low 2*WIDTH bits of ext(x)·ext(y), which is the exact product in either mode;
  - `valid` ← 1;
  - state ← IDLE.
- `start` while `busy`=1 is ignored. It is not queued.
- Changes to `x`, `y` or `signed_mode` during RUN have no effect.
- `result` keeps its previous value throughout RUN. It changes only on the completing edge, or on reset.

## Timing
- Reset values, applied on the edge where `reset`=1:
  - `result`=0, `valid`=0, `busy`=0;
  - state IDLE;
  - counter and accumulator 0.
- Reset has priority over everything, including `start` on the same edge.
- Reset mid-operation: the operation is abandoned and no `valid` pulse is produced. A `start` on the first edge with `reset`=0 is accepted normally.
- Latency: `start` accepted at edge k gives:
  - `busy`=1 from edge k to edge k+N;
  - `result` updated and `valid`=1 after edge k+N;
  - `valid` back to 0 after edge k+N+1, unless another completion occurs then (impossible, since N ≥ 3).
- Back-to-back: `busy`=0 in the cycle where `valid`=1, so a `start` on edge k+N+1 is accepted. Issue interval is N+1 clocks.
- `valid` never asserts without a preceding accepted `start`.

## Test plan
- Signed, WIDTH=32: x=0xFFFFFFFD (−3), y=7, start at edge k → `result`=0xFFFFFFFFFFFFFFEB. `valid` pulses exactly one cycle after edge k+17; `busy` is high for 17 cycles.
- Unsigned, WIDTH=32:
  - x=y=0xFFFFFFFF → 0xFFFFFFFE00000001;
  - the same operands with `signed_mode`=1 → 0x0000000000000001.
- Corner values, signed, WIDTH=32:
  - x=y=0x80000000 → 0x4000000000000000;
  - x=0x80000000, y=0x7FFFFFFF → 0xC000000080000000;
  - x=0, y=anything → 0.
- Handshake:
  - re-assert `start` and change `x`/`y` mid-RUN → no restart, result matches the originally latched operands;
  - `start` on the `valid` cycle → second product delivered N+1 cycles later;
  - `result` stays stable during RUN.
- Reset during RUN at step 5:
  - next cycle `busy`=0, `valid`=0, `result`=0;
  - no late `valid`;
  - an immediate new `start` gives the correct product.
- WIDTH=8, exhaustive over all x, y in both modes, compared against a reference product:
  - every result correct;
  - latency always 5 cycles;
  - exactly one `valid` per accepted `start`.
